// File: rtl/sseg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sseg_pkg
// Description : Shared types and segment-pattern constants for the
//               seven-segment scan capture monitor.
// Revision    : 1.0 - initial release
// ============================================================================
package sseg_pkg;

    localparam int SEG_W    = 7;
    localparam int DIGITS   = 4;
    localparam int NIBBLE_W = 4;
    localparam int IDX_W    = $clog2(DIGITS);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DONE    = 2'd2
    } state_t;

    // Normalised gfedcba patterns, 1 = lit segment
    localparam logic [SEG_W-1:0] SEG_0 = 7'h3F;
    localparam logic [SEG_W-1:0] SEG_1 = 7'h06;
    localparam logic [SEG_W-1:0] SEG_2 = 7'h5B;
    localparam logic [SEG_W-1:0] SEG_3 = 7'h4F;
    localparam logic [SEG_W-1:0] SEG_4 = 7'h66;
    localparam logic [SEG_W-1:0] SEG_5 = 7'h6D;
    localparam logic [SEG_W-1:0] SEG_6 = 7'h7D;
    localparam logic [SEG_W-1:0] SEG_7 = 7'h07;
    localparam logic [SEG_W-1:0] SEG_8 = 7'h7F;
    localparam logic [SEG_W-1:0] SEG_9 = 7'h6F;
    localparam logic [SEG_W-1:0] SEG_A = 7'h77;
    localparam logic [SEG_W-1:0] SEG_B = 7'h7C;
    localparam logic [SEG_W-1:0] SEG_C = 7'h39;
    localparam logic [SEG_W-1:0] SEG_D = 7'h5E;
    localparam logic [SEG_W-1:0] SEG_E = 7'h79;
    localparam logic [SEG_W-1:0] SEG_F = 7'h71;

    localparam logic [15:0][SEG_W-1:0] SEG_TABLE = {
        SEG_F, SEG_E, SEG_D, SEG_C, SEG_B, SEG_A, SEG_9, SEG_8,
        SEG_7, SEG_6, SEG_5, SEG_4, SEG_3, SEG_2, SEG_1, SEG_0
    };

endpackage
`default_nettype wire

// File: rtl/sseg_decode.sv
`default_nettype none
// ============================================================================
// Module      : sseg_decode
// Description : Combinational lookup from a normalised 7-segment pattern to
//               a hex nibble plus a valid flag.
// Revision    : 1.0 - initial release
// ============================================================================
module sseg_decode
    import sseg_pkg::*;
(
    input  logic [SEG_W-1:0]    pattern,
    output logic                valid,
    output logic [NIBBLE_W-1:0] nibble
);

    always_comb begin
        valid  = 1'b0;
        nibble = '0;
        for (int i = 0; i < 16; i++) begin
            if (pattern == SEG_TABLE[i]) begin
                valid  = 1'b1;
                nibble = NIBBLE_W'(i);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/sseg_scan_capture.sv
`default_nettype none
// ============================================================================
// Module      : sseg_scan_capture
// Description : Samples a multiplexed anode/segment bus, debounces each digit,
//               decodes it and reports complete 4-digit frames.
//               Optional: SSEG_RAW_CAPTURE_EN adds the raw_seg output.
// Revision    : 1.0 - initial release
// ============================================================================
module sseg_scan_capture
    import sseg_pkg::*;
#(
    parameter int STABLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int AN_ACTIVE_LOW  = 1,
    parameter int SEG_ACTIVE_LOW = 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [SEG_W-1:0]             seg,
    input  logic [DIGITS-1:0]            an,
    output logic [DIGITS*NIBBLE_W-1:0]   frame_data,
    output logic                         frame_valid,
    output logic [DIGITS-1:0]            digit_err,
`ifdef SSEG_RAW_CAPTURE_EN
    output logic [DIGITS*SEG_W-1:0]      raw_seg,
`endif
    output logic                         timeout
);

    localparam logic [7:0]  STABLE_LAST = 8'(STABLE_CYCLES - 1);
    localparam logic [15:0] TOUT_LAST   = 16'(TIMEOUT_CYCLES - 1);

    logic [SEG_W-1:0]               seg_q;
    logic [DIGITS-1:0]              an_q;
    logic [SEG_W-1:0]               seg_n;
    logic [DIGITS-1:0]              an_n;
    logic                           sample_valid;
    logic [IDX_W-1:0]               sample_idx;
    logic [SEG_W-1:0]               prev_seg;
    logic [IDX_W-1:0]               prev_idx;
    logic                           prev_valid;
    logic [7:0]                     stable_cnt;
    logic [7:0]                     stable_cnt_next;
    logic                           same;
    logic                           accept;
    logic                           dec_valid;
    logic [NIBBLE_W-1:0]            dec_nibble;

    state_t                         state;
    state_t                         state_next;
    logic [DIGITS-1:0]              seen;
    logic [DIGITS-1:0]              seen_next;
    logic [DIGITS-1:0]              sel_mask;
    logic [DIGITS-1:0][NIBBLE_W-1:0] shadow_nib;
    logic [DIGITS-1:0][NIBBLE_W-1:0] shadow_nib_next;
    logic [DIGITS-1:0]              shadow_err;
    logic [DIGITS-1:0]              shadow_err_next;
    logic [15:0]                    tout_cnt;
    logic [15:0]                    tout_cnt_next;
    logic                           frame_load;
    logic                           timeout_next;

    assign seg_n        = (SEG_ACTIVE_LOW != 0) ? ~seg_q : seg_q;
    assign an_n         = (AN_ACTIVE_LOW != 0)  ? ~an_q  : an_q;
    assign sample_valid = $onehot(an_n);
    assign sel_mask     = {{(DIGITS-1){1'b0}}, 1'b1} << sample_idx;

    always_comb begin
        sample_idx = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (an_n[i]) begin
                sample_idx = IDX_W'(i);
            end
        end
    end

    assign same = sample_valid && prev_valid &&
                  (sample_idx == prev_idx) && (seg_n == prev_seg);

    always_comb begin
        stable_cnt_next = sample_valid ? 8'd1 : 8'd0;
        if (same) begin
            stable_cnt_next = (stable_cnt == 8'hFF) ? stable_cnt : stable_cnt + 8'd1;
        end
    end

    // Counter is monotonic within a run, so this fires once per stable run
    assign accept = same ? (stable_cnt == STABLE_LAST)
                         : (sample_valid && (STABLE_CYCLES == 1));

    sseg_decode u_decode (
        .pattern (seg_n),
        .valid   (dec_valid),
        .nibble  (dec_nibble)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            seg_q      <= '0;
            an_q       <= '0;
            prev_seg   <= '0;
            prev_idx   <= '0;
            prev_valid <= 1'b0;
            stable_cnt <= '0;
        end else begin
            seg_q      <= seg;
            an_q       <= an;
            prev_seg   <= seg_n;
            prev_idx   <= sample_idx;
            prev_valid <= sample_valid;
            stable_cnt <= stable_cnt_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next      = state;
        seen_next       = seen;
        shadow_nib_next = shadow_nib;
        shadow_err_next = shadow_err;
        tout_cnt_next   = tout_cnt;
        frame_load      = 1'b0;
        timeout_next    = 1'b0;

        if (accept) begin
            shadow_nib_next[sample_idx] = dec_valid ? dec_nibble : '0;
            shadow_err_next[sample_idx] = ~dec_valid;
        end

        case (state)
            IDLE: begin
                tout_cnt_next = '0;
                if (accept) begin
                    seen_next  = sel_mask;
                    state_next = COLLECT;
                end
            end
            COLLECT: begin
                if (accept) begin
                    seen_next     = seen | sel_mask;
                    tout_cnt_next = '0;
                    if (&seen_next) begin
                        frame_load = 1'b1;
                        state_next = DONE;
                    end
                end else if (tout_cnt == TOUT_LAST) begin
                    timeout_next    = 1'b1;
                    seen_next       = '0;
                    shadow_err_next = '0;
                    tout_cnt_next   = '0;
                    state_next      = IDLE;
                end else begin
                    tout_cnt_next = tout_cnt + 16'd1;
                end
            end
            DONE: begin
                // Output registers were loaded on entry; start the next frame
                seen_next     = accept ? sel_mask : '0;
                tout_cnt_next = '0;
                state_next    = COLLECT;
            end
            default: begin
                seen_next  = '0;
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            seen        <= '0;
            shadow_nib  <= '0;
            shadow_err  <= '0;
            tout_cnt    <= '0;
            frame_data  <= '0;
            digit_err   <= '0;
            frame_valid <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            seen        <= seen_next;
            shadow_nib  <= shadow_nib_next;
            shadow_err  <= shadow_err_next;
            tout_cnt    <= tout_cnt_next;
            frame_valid <= frame_load;
            timeout     <= timeout_next;
            if (frame_load) begin
                frame_data <= shadow_nib_next;
                digit_err  <= shadow_err_next;
            end
        end
    end

`ifdef SSEG_RAW_CAPTURE_EN
    logic [DIGITS-1:0][SEG_W-1:0] shadow_raw;
    logic [DIGITS-1:0][SEG_W-1:0] shadow_raw_next;

    always_comb begin
        shadow_raw_next = shadow_raw;
        if (accept) begin
            shadow_raw_next[sample_idx] = seg_n;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            shadow_raw <= '0;
            raw_seg    <= '0;
        end else begin
            shadow_raw <= shadow_raw_next;
            if (frame_load) begin
                raw_seg <= shadow_raw_next;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_sseg_scan_capture.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_sseg_scan_capture
// Description : Randomised bench for sseg_scan_capture against a cycle-level
//               reference built from pin history.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sseg_scan_capture;

    localparam int STABLE = 4;
    localparam int TOUT   = 1024;

    localparam logic [6:0] SEG_TAB [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [6:0]  seg = 7'h7F;
    logic [3:0]  an = 4'hF;
    logic [15:0] frame_data;
    logic        frame_valid;
    logic [3:0]  digit_err;
    logic        timeout;
`ifdef SSEG_RAW_CAPTURE_EN
    logic [27:0] raw_seg;
`endif

    sseg_scan_capture #(
        .STABLE_CYCLES  (STABLE),
        .TIMEOUT_CYCLES (TOUT),
        .AN_ACTIVE_LOW  (1),
        .SEG_ACTIVE_LOW (1)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .seg         (seg),
        .an          (an),
        .frame_data  (frame_data),
        .frame_valid (frame_valid),
        .digit_err   (digit_err),
`ifdef SSEG_RAW_CAPTURE_EN
        .raw_seg     (raw_seg),
`endif
        .timeout     (timeout)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [4:0] ref_decode(input logic [6:0] p);
        for (int v = 0; v < 16; v++) begin
            if (SEG_TAB[v] == p) return {1'b1, 4'(v)};
        end
        return 5'b0;
    endfunction

    // Reference state: pin history {valid, an, seg}, newest at index 0
    logic [11:0] hist [STABLE+1];
    logic [3:0]  m_nib [4];
    logic [6:0]  m_raw [4];
    logic [3:0]  m_err;
    logic [3:0]  mask;
    bit          in_frame, done_pending;
    int          idle;
    logic [15:0] e_data;
    logic [3:0]  e_err;
    logic [27:0] e_raw;
    bit          e_valid, e_tout;
    int          dut_frames = 0;
    int          dut_touts = 0;

    always @(posedge clk) begin : model
        bit         acc;
        int         d;
        logic [4:0] dec;
        logic [6:0] pn;
        logic [11:0] cur;
        if (!reset) begin
            for (int k = 0; k <= STABLE; k++) hist[k] = 12'h000;
            for (int k = 0; k < 4; k++) begin
                m_nib[k] = 4'h0;
                m_raw[k] = 7'h00;
            end
            m_err = 4'h0; mask = 4'h0; in_frame = 0; done_pending = 0; idle = 0;
            e_data = 16'h0; e_err = 4'h0; e_raw = 28'h0; e_valid = 0; e_tout = 0;
        end else begin
            acc = hist[0][11];
            for (int k = 1; k < STABLE; k++) if (hist[k] != hist[0]) acc = 0;
            if (hist[STABLE][11] && hist[STABLE] == hist[0]) acc = 0;
            d = 0;
            for (int k = 0; k < 4; k++) if (!hist[0][7+k]) d = k;
            pn  = ~hist[0][6:0];
            dec = ref_decode(pn);
            e_valid = 0;
            e_tout  = 0;
            if (acc) begin
                m_nib[d] = dec[4] ? dec[3:0] : 4'h0;
                m_err[d] = ~dec[4];
                m_raw[d] = pn;
            end
            if (done_pending) begin
                done_pending = 0; in_frame = 1; idle = 0;
                mask = 4'h0;
                if (acc) mask[d] = 1'b1;
            end else if (acc) begin
                mask[d] = 1'b1; in_frame = 1; idle = 0;
                if (mask == 4'hF) begin
                    e_valid = 1;
                    e_data  = {m_nib[3], m_nib[2], m_nib[1], m_nib[0]};
                    e_err   = m_err;
                    e_raw   = {m_raw[3], m_raw[2], m_raw[1], m_raw[0]};
                    done_pending = 1;
                end
            end else if (in_frame) begin
                idle++;
                if (idle == TOUT) begin
                    e_tout = 1; in_frame = 0; mask = 4'h0; m_err = 4'h0; idle = 0;
                end
            end
            cur = ($countones(~an) == 1) ? {1'b1, an, seg} : 12'h000;
            for (int k = STABLE; k > 0; k--) hist[k] = hist[k-1];
            hist[0] = cur;
        end
        #1;
        check_val("frame_valid", 32'(frame_valid), 32'(e_valid));
        check_val("timeout", 32'(timeout), 32'(e_tout));
        check_val("frame_data", 32'(frame_data), 32'(e_data));
        check_val("digit_err", 32'(digit_err), 32'(e_err));
`ifdef SSEG_RAW_CAPTURE_EN
        check_val("raw_seg", 32'(raw_seg), 32'(e_raw));
`endif
        if (frame_valid === 1'b1) dut_frames++;
        if (timeout === 1'b1) dut_touts++;
    end

    task automatic drive(input logic [3:0] a, input logic [6:0] s, input int n);
        an  = a;
        seg = s;
        repeat (n) @(negedge clk);
    endtask

    task automatic show(input int d, input logic [6:0] pat, input int n);
        drive(~(4'b0001 << d), ~pat, n);
    endtask

    task automatic scan(input logic [6:0] p0, input logic [6:0] p1,
                        input logic [6:0] p2, input logic [6:0] p3, input int n);
        show(0, p0, n); show(1, p1, n); show(2, p2, n); show(3, p3, n);
    endtask

    int f0, t0;
    logic [27:0] raw_exp;

    initial begin
        reset = 1'b0;
        drive(4'($urandom), 7'($urandom), 3);
        check_val("rst_data", 32'(frame_data), 32'h0);
        check_val("rst_valid", 32'(frame_valid), 32'h0);
        reset = 1'b1;

        f0 = dut_frames;
        show(0, 7'h3F, 4);
        drive(4'hF, 7'h7F, 2);
        check_val("single_accept_frames", 32'(dut_frames - f0), 32'd0);

        f0 = dut_frames;
        scan(SEG_TAB[1], SEG_TAB[2], SEG_TAB[3], SEG_TAB[4], 8);
        check_val("scan1234_data", 32'(frame_data), 32'h4321);
        check_val("scan1234_err", 32'(digit_err), 32'h0);
        check_val("scan1234_frames", 32'(dut_frames - f0), 32'd1);

        scan(SEG_TAB[1], SEG_TAB[2], 7'h00, SEG_TAB[4], 8);
        check_val("blank_digit_data", 32'(frame_data), 32'h4021);
        check_val("blank_digit_err", 32'(digit_err), 32'h4);

        show(1, SEG_TAB[1], 2);
        show(1, SEG_TAB[2], 1);
        show(1, SEG_TAB[1], 4);
        drive(4'b1100, ~SEG_TAB[3], 10);

        f0 = dut_frames; t0 = dut_touts;
        show(0, SEG_TAB[5], 8);
        show(1, SEG_TAB[6], 8);
        drive(4'hF, 7'h7F, TOUT + 5);
        check_val("timeout_pulses", 32'(dut_touts - t0), 32'd1);
        check_val("timeout_frames", 32'(dut_frames - f0), 32'd0);
        check_val("timeout_hold_data", 32'(frame_data), 32'h4021);
        scan(SEG_TAB[9], SEG_TAB[8], SEG_TAB[7], SEG_TAB[6], 8);
        check_val("scan6789_data", 32'(frame_data), 32'h6789);

        f0 = dut_frames; t0 = dut_touts;
        show(0, SEG_TAB[1], 8); show(1, SEG_TAB[1], 8); show(2, SEG_TAB[1], 8);
        reset = 1'b0;
        drive(4'($urandom), 7'($urandom), 2);
        reset = 1'b1;
        check_val("midreset_frames", 32'(dut_frames - f0), 32'd0);
        check_val("midreset_touts", 32'(dut_touts - t0), 32'd0);
        check_val("midreset_data", 32'(frame_data), 32'h0);
        scan(SEG_TAB[10], SEG_TAB[11], SEG_TAB[12], SEG_TAB[13], 8);
        check_val("scanDCBA_data", 32'(frame_data), 32'hDCBA);
`ifdef SSEG_RAW_CAPTURE_EN
        raw_exp = {7'h5E, 7'h39, 7'h7C, 7'h77};
        check_val("scanDCBA_raw", 32'(raw_seg), 32'(raw_exp));
`endif

        for (int it = 0; it < 60; it++) begin
            int mode;
            mode = $urandom_range(0, 19);
            if (mode < 12) begin
                for (int d = 0; d < 4; d++) begin
                    logic [6:0] p;
                    p = ($urandom_range(0, 4) == 0) ? 7'($urandom) : SEG_TAB[$urandom_range(0, 15)];
                    show(d, p, $urandom_range(3, 9));
                end
            end else if (mode < 15) begin
                drive(4'($urandom), 7'($urandom), $urandom_range(1, 12));
            end else if (mode < 17) begin
                drive(4'hF, 7'($urandom), $urandom_range(1, 40));
            end else if (mode < 18) begin
                drive(4'hF, 7'h7F, TOUT + $urandom_range(0, 20));
            end else begin
                reset = 1'b0;
                drive(4'($urandom), 7'($urandom), $urandom_range(1, 2));
                reset = 1'b1;
            end
        end

        drive(4'hF, 7'h7F, 5);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
